// File: rtl/mult_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared definitions for the multiply/divide unit: operation codes as issued by
// the control unit, the MDU sequencing states and a small constant helper.
// -----------------------------------------------------------------------------
package mult_div_unit_pkg;

  // Operation codes carried on the op bus; 6 and 7 are reserved no-ops.
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_RSV6  = 3'd6,
    MDU_RSV7  = 3'd7
  } mdu_op_e;

  // Sequencer states; anything other than idle means an operation is in flight.
  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'd0,
    MDU_ST_MUL  = 2'd1,
    MDU_ST_DIV  = 2'd2
  } mdu_state_e;

  // Larger of two cycle counts, used to size the shared busy counter.
  function automatic int unsigned mdu_max(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/mult_div_unit_divider.sv
// -----------------------------------------------------------------------------
// mdu_divider
// Purely combinational quotient/remainder for signed and unsigned division.
// Signed division works on magnitudes and re-applies signs: the quotient is
// truncated toward zero and the remainder takes the sign of the dividend.
// Two operand cases are resolved explicitly rather than by the arithmetic:
//   divisor == 0                     -> quotient all ones, remainder = dividend
//   signed most-negative / -1        -> quotient most-negative, remainder 0
// Ports:
//   dividend_i  WIDTH  dividend (latched rs)
//   divisor_i   WIDTH  divisor  (latched rt)
//   signed_i    1      1 = two's-complement operands, 0 = unsigned
//   quot_o      WIDTH  quotient  (destined for LO)
//   rem_o       WIDTH  remainder (destined for HI)
// -----------------------------------------------------------------------------
module mdu_divider
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             signed_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam logic [WIDTH-1:0] Zero    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] One     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH-1){1'b0}}};

  logic             dvd_neg_s;
  logic             dvs_neg_s;
  logic             div_zero_s;
  logic             overflow_s;
  logic [WIDTH-1:0] dvd_mag_s;
  logic [WIDTH-1:0] dvs_mag_s;
  logic [WIDTH-1:0] dvs_safe_s;
  logic [WIDTH-1:0] q_mag_s;
  logic [WIDTH-1:0] r_mag_s;

  assign dvd_neg_s  = signed_i & dividend_i[WIDTH-1];
  assign dvs_neg_s  = signed_i & divisor_i[WIDTH-1];
  assign div_zero_s = (divisor_i == Zero);
  assign overflow_s = signed_i & (dividend_i == MostNeg) & (divisor_i == AllOnes);

  // Magnitudes; the most-negative value maps to itself, which read unsigned
  // is exactly its magnitude, so no extra bit is needed.
  assign dvd_mag_s  = dvd_neg_s ? ((~dividend_i) + One) : dividend_i;
  assign dvs_mag_s  = dvs_neg_s ? ((~divisor_i) + One) : divisor_i;

  // Keep the divider datapath free of an X-producing divide by zero; the
  // zero case is overridden below anyway.
  assign dvs_safe_s = div_zero_s ? One : dvs_mag_s;
  assign q_mag_s    = dvd_mag_s / dvs_safe_s;
  assign r_mag_s    = dvd_mag_s % dvs_safe_s;

  // Select the special-case result or re-sign the magnitude result.
  always_comb begin
    quot_o = Zero;
    rem_o  = Zero;
    if (div_zero_s) begin
      quot_o = AllOnes;
      rem_o  = dividend_i;
    end else if (overflow_s) begin
      quot_o = MostNeg;
      rem_o  = Zero;
    end else begin
      quot_o = (dvd_neg_s ^ dvs_neg_s) ? ((~q_mag_s) + One) : q_mag_s;
      rem_o  = dvd_neg_s ? ((~r_mag_s) + One) : r_mag_s;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// MIPS-style HI/LO multiply/divide unit. A multiply or divide is accepted only
// when idle; operands are latched, busy rises for a fixed number of cycles and
// HI/LO are written once at the end. MTHI/MTLO write HI/LO directly from idle
// in a single cycle. Starts presented while busy are dropped: the issuer must
// stall on busy.
// Ports:
//   clk    1      clock, rising edge
//   reset  1      asynchronous active-low reset
//   start  1      request strobe
//   op     3      operation code (mdu_op_e)
//   a      WIDTH  rs: multiplicand / dividend / MTHI-MTLO data
//   b      WIDTH  rt: multiplier / divisor
//   busy   1      registered, high while a multiply/divide is in flight
//   hi     WIDTH  HI register
//   lo     WIDTH  LO register
// -----------------------------------------------------------------------------
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MaxCycles = mdu_max(MUL_CYCLES, DIV_CYCLES);
  localparam int          CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0]  CntZero = {CntW{1'b0}};
  localparam logic [CntW-1:0]  CntOne  = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [CntW-1:0]  CntMul  = CntW'(MUL_CYCLES);
  localparam logic [CntW-1:0]  CntDiv  = CntW'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] Zero    = {WIDTH{1'b0}};

  mdu_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  mdu_op_e          op_q,    op_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;
  logic             busy_q;

  mdu_op_e            op_s;
  logic               mul_signed_s;
  logic [2*WIDTH-1:0] mul_a_ext_s;
  logic [2*WIDTH-1:0] mul_b_ext_s;
  logic [2*WIDTH-1:0] product_s;
  logic               div_signed_s;
  logic [WIDTH-1:0]   div_quot_s;
  logic [WIDTH-1:0]   div_rem_s;

  assign op_s = mdu_op_e'(op);

  // Multiply: sign- or zero-extend both latched operands to 2*WIDTH; the low
  // 2*WIDTH bits of that product are the exact full-width result either way.
  assign mul_signed_s = (op_q == MDU_MULT);
  assign mul_a_ext_s  = {{WIDTH{mul_signed_s & a_q[WIDTH-1]}}, a_q};
  assign mul_b_ext_s  = {{WIDTH{mul_signed_s & b_q[WIDTH-1]}}, b_q};
  assign product_s    = mul_a_ext_s * mul_b_ext_s;

  assign div_signed_s = (op_q == MDU_DIV);

  mdu_divider #(
    .WIDTH (WIDTH)
  ) u_divider (
    .dividend_i (a_q),
    .divisor_i  (b_q),
    .signed_i   (div_signed_s),
    .quot_o     (div_quot_s),
    .rem_o      (div_rem_s)
  );

  // Next-state logic: accept requests in idle, count down while busy and
  // commit HI/LO on the cycle the counter expires.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      MDU_ST_IDLE: begin
        if (start) begin
          case (op_s)
            MDU_MULT, MDU_MULTU: begin
              a_d     = a;
              b_d     = b;
              op_d    = op_s;
              cnt_d   = CntMul;
              state_d = MDU_ST_MUL;
            end
            MDU_DIV, MDU_DIVU: begin
              a_d     = a;
              b_d     = b;
              op_d    = op_s;
              cnt_d   = CntDiv;
              state_d = MDU_ST_DIV;
            end
            MDU_MTHI: hi_d = a;
            MDU_MTLO: lo_d = a;
            default: begin
              // Reserved codes leave every register untouched.
              state_d = MDU_ST_IDLE;
            end
          endcase
        end else begin
          state_d = MDU_ST_IDLE;
        end
      end

      MDU_ST_MUL: begin
        cnt_d = cnt_q - CntOne;
        // cnt_q == 1 is the edge at which the counter reaches zero.
        if (cnt_q == CntOne) begin
          {hi_d, lo_d} = product_s;
          state_d      = MDU_ST_IDLE;
        end else begin
          state_d = MDU_ST_MUL;
        end
      end

      MDU_ST_DIV: begin
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          hi_d    = div_rem_s;
          lo_d    = div_quot_s;
          state_d = MDU_ST_IDLE;
        end else begin
          state_d = MDU_ST_DIV;
        end
      end

      default: begin
        // Unreachable encoding: recover to idle without touching HI/LO.
        cnt_d   = CntZero;
        state_d = MDU_ST_IDLE;
      end
    endcase
  end

  // State, counter, latched operands and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MDU_ST_IDLE;
      cnt_q   <= CntZero;
      a_q     <= Zero;
      b_q     <= Zero;
      op_q    <= MDU_MULT;
      hi_q    <= Zero;
      lo_q    <= Zero;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Registered busy flag, tracking whether the next state is non-idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= (state_d != MDU_ST_IDLE);
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
// Two instances: a default 32-bit unit (5/10 cycles) and a 16-bit unit with
// single-cycle multiply and divide. Expected HI/LO come from a plain-arithmetic
// model of the MIPS HI/LO semantics; expected latencies from the parameters.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;

  logic        w_start;
  logic [2:0]  w_op;
  logic [31:0] w_a, w_b;
  logic        w_busy;
  logic [31:0] w_hi, w_lo;

  logic        n_start;
  logic [2:0]  n_op;
  logic [15:0] n_a, n_b;
  logic        n_busy;
  logic [15:0] n_hi, n_lo;

  int checks = 0;
  int errors = 0;

  // Model state for each instance (narrow values kept zero-extended).
  logic [31:0] m_hi_w = 32'd0, m_lo_w = 32'd0;
  logic [31:0] m_hi_n = 32'd0, m_lo_n = 32'd0;

  mult_div_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) u_wide (
    .clk(clk), .reset(reset), .start(w_start), .op(w_op), .a(w_a), .b(w_b),
    .busy(w_busy), .hi(w_hi), .lo(w_lo)
  );

  mult_div_unit #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(1)) u_narrow (
    .clk(clk), .reset(reset), .start(n_start), .op(n_op), .a(n_a), .b(n_b),
    .busy(n_busy), .hi(n_hi), .lo(n_lo)
  );

  always #5 clk = ~clk;

  // Reference model: HI/LO after one operation on a w-bit unit.
  function automatic void ref_model(input int w, input logic [2:0] op,
                                    input logic [31:0] a, input logic [31:0] b,
                                    inout logic [31:0] hi, inout logic [31:0] lo);
    logic [63:0] mask, ua, ub, p;
    longint sa, sb, sp, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = longint'(ua);
    sb = longint'(ub);
    if (ua[w-1]) sa = sa - (longint'(1) << w);
    if (ub[w-1]) sb = sb - (longint'(1) << w);
    case (op)
      3'd0: begin sp = sa * sb; p = 64'(sp);
                  hi = 32'((p >> w) & mask); lo = 32'(p & mask); end
      3'd1: begin p = ua * ub; hi = 32'((p >> w) & mask); lo = 32'(p & mask); end
      3'd2: begin
        if (ub == 64'd0) begin lo = 32'(mask); hi = 32'(ua); end
        else if (sa == -(longint'(1) << (w - 1)) && sb == -64'sd1) begin
          lo = 32'(ua); hi = 32'd0;
        end else begin
          q = sa / sb; r = sa % sb;
          lo = 32'(64'(q) & mask); hi = 32'(64'(r) & mask);
        end
      end
      3'd3: begin
        if (ub == 64'd0) begin lo = 32'(mask); hi = 32'(ua); end
        else begin lo = 32'(ua / ub); hi = 32'(ua % ub); end
      end
      3'd4: hi = 32'(ua);
      3'd5: lo = 32'(ua);
      default: ;
    endcase
  endfunction

  function automatic int exp_cycles(input bit nar, input logic [2:0] op);
    if (op == 3'd0 || op == 3'd1) return nar ? 1 : 5;
    if (op == 3'd2 || op == 3'd3) return nar ? 1 : 10;
    return 0;
  endfunction

  function automatic logic busy_of(input bit nar);
    return nar ? n_busy : w_busy;
  endfunction
  function automatic logic [31:0] hi_of(input bit nar);
    return nar ? {16'd0, n_hi} : w_hi;
  endfunction
  function automatic logic [31:0] lo_of(input bit nar);
    return nar ? {16'd0, n_lo} : w_lo;
  endfunction

  // Present one start for one cycle, then scramble operands so that only the
  // latched values can influence the result.
  task automatic issue(input bit nar, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (nar) begin n_start = 1'b1; n_op = op; n_a = a[15:0]; n_b = b[15:0]; end
    else     begin w_start = 1'b1; w_op = op; w_a = a;       w_b = b;       end
    @(posedge clk); #1;
    w_start = 1'b0; n_start = 1'b0;
    w_op = 3'($urandom); w_a = $urandom; w_b = $urandom;
    n_op = 3'($urandom); n_a = 16'($urandom); n_b = 16'($urandom);
  endtask

  // Issue an op and count edges after acceptance until busy is low (bounded);
  // held reports whether HI/LO kept their pre-op model values while busy.
  task automatic run_op(input bit nar, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        output int n, output bit held);
    logic [31:0] ph, pl;
    ph = nar ? m_hi_n : m_hi_w;
    pl = nar ? m_lo_n : m_lo_w;
    issue(nar, op, a, b);
    n = 0; held = 1'b1;
    while (busy_of(nar) && n < 200) begin
      if (hi_of(nar) !== ph || lo_of(nar) !== pl) held = 1'b0;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    w_start = 1'b0; w_op = 3'd0; w_a = 32'd0; w_b = 32'd0;
    n_start = 1'b0; n_op = 3'd0; n_a = 16'd0; n_b = 16'd0;
    #3;
    checks++;
    if (w_busy !== 1'b0 || w_hi !== 32'd0 || w_lo !== 32'd0) begin
      errors++; $display("FAIL reset_wide: busy=%b hi=%h lo=%h expected 0/0/0", w_busy, w_hi, w_lo);
    end
    checks++;
    if (n_busy !== 1'b0 || n_hi !== 16'd0 || n_lo !== 16'd0) begin
      errors++; $display("FAIL reset_narrow: busy=%b hi=%h lo=%h expected 0/0/0", n_busy, n_hi, n_lo);
    end
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (w_busy !== 1'b0 || w_hi !== 32'd0 || w_lo !== 32'd0) begin
      errors++; $display("FAIL reset_idle: busy=%b hi=%h lo=%h expected 0/0/0", w_busy, w_hi, w_lo);
    end
  endtask

  // Directed 32-bit vectors with hand-derived HI/LO values.
  task automatic test_directed_wide;
    logic [2:0]  t_op [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd4, 3'd5};
    logic [31:0] t_a  [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7,
                              32'h80000000, 32'hDEADBEEF, 32'h00001234};
    logic [31:0] t_b  [7] = '{32'd7, 32'd2, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] t_hi [7] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000007,
                              32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF};
    logic [31:0] t_lo [7] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF,
                              32'h80000000, 32'h80000000, 32'h00001234};
    int n; bit held;
    for (int i = 0; i < 7; i++) begin
      run_op(1'b0, t_op[i], t_a[i], t_b[i], n, held);
      ref_model(32, t_op[i], t_a[i], t_b[i], m_hi_w, m_lo_w);
      checks++;
      if (n !== exp_cycles(1'b0, t_op[i])) begin
        errors++; $display("FAIL dir_cycles[%0d]: got %0d expected %0d", i, n, exp_cycles(1'b0, t_op[i]));
      end
      checks++;
      if (w_hi !== t_hi[i] || w_lo !== t_lo[i]) begin
        errors++; $display("FAIL dir_result[%0d]: hi=%h lo=%h expected hi=%h lo=%h", i, w_hi, w_lo, t_hi[i], t_lo[i]);
      end
      if (n > 0) begin
        checks++;
        if (!held) begin errors++; $display("FAIL dir_hold[%0d]: HI/LO changed while busy", i); end
      end
    end
  endtask

  // Starts presented while busy (MTLO, then DIV) must be dropped.
  task automatic test_busy_ignore;
    int n;
    w_start = 1'b1; w_op = 3'd1; w_a = 32'hFFFFFFFF; w_b = 32'd2;
    @(posedge clk); #1;
    w_op = 3'd5; w_a = 32'h00001234;
    @(posedge clk); #1;
    checks++;
    if (w_busy !== 1'b1 || w_lo !== m_lo_w || w_hi !== m_hi_w) begin
      errors++; $display("FAIL busy_ignore_mtlo: busy=%b lo=%h hi=%h expected 1/%h/%h", w_busy, w_lo, w_hi, m_lo_w, m_hi_w);
    end
    w_op = 3'd2; w_a = 32'd100; w_b = 32'd3;
    @(posedge clk); #1;
    w_start = 1'b0;
    n = 2;
    while (w_busy && n < 200) begin @(posedge clk); #1; n++; end
    ref_model(32, 3'd1, 32'hFFFFFFFF, 32'd2, m_hi_w, m_lo_w);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL busy_ignore_cycles: got %0d expected 5", n); end
    checks++;
    if (w_hi !== 32'h00000001 || w_lo !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL busy_ignore_result: hi=%h lo=%h expected 00000001/fffffffe", w_hi, w_lo);
    end
  endtask

  // 16-bit, single-cycle instance: directed vectors issued back-to-back.
  task automatic test_back_to_back_narrow;
    logic [2:0]  t_op [5] = '{3'd0, 3'd2, 3'd3, 3'd2, 3'd1};
    logic [31:0] t_a  [5] = '{32'hFFFD, 32'hFFF9, 32'd7, 32'h8000, 32'hFFFF};
    logic [31:0] t_b  [5] = '{32'd7, 32'd2, 32'd0, 32'hFFFF, 32'hFFFF};
    logic [31:0] t_hi [5] = '{32'hFFFF, 32'hFFFF, 32'h0007, 32'h0000, 32'hFFFE};
    logic [31:0] t_lo [5] = '{32'hFFEB, 32'hFFFD, 32'hFFFF, 32'h8000, 32'h0001};
    int n; bit held;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b1, t_op[i], t_a[i], t_b[i], n, held);
      ref_model(16, t_op[i], t_a[i], t_b[i], m_hi_n, m_lo_n);
      checks++;
      if (n !== 1) begin errors++; $display("FAIL b2b_cycles[%0d]: got %0d expected 1", i, n); end
      checks++;
      if ({16'd0, n_hi} !== t_hi[i] || {16'd0, n_lo} !== t_lo[i]) begin
        errors++; $display("FAIL b2b_result[%0d]: hi=%h lo=%h expected hi=%h lo=%h", i, n_hi, n_lo, t_hi[i][15:0], t_lo[i][15:0]);
      end
    end
  endtask

  // Random ops on both instances against the model, with corner operands mixed in.
  task automatic test_random;
    int n; bit held;
    logic [2:0] op; logic [31:0] a, b;
    for (int k = 0; k < 90; k++) begin
      bit nar;
      nar = (k >= 60);
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = nar ? 32'h8000 : 32'h80000000; b = nar ? 32'hFFFF : 32'hFFFFFFFF; end
        2: b = {28'd0, 4'($urandom)};
        default: ;
      endcase
      if (nar) begin a = a & 32'hFFFF; b = b & 32'hFFFF; end
      run_op(nar, op, a, b, n, held);
      if (nar) ref_model(16, op, a, b, m_hi_n, m_lo_n);
      else     ref_model(32, op, a, b, m_hi_w, m_lo_w);
      checks++;
      if (n !== exp_cycles(nar, op)) begin
        errors++; $display("FAIL rand_cycles[%0d] op=%0d: got %0d expected %0d", k, op, n, exp_cycles(nar, op));
      end
      checks++;
      if (hi_of(nar) !== (nar ? m_hi_n : m_hi_w) || lo_of(nar) !== (nar ? m_lo_n : m_lo_w)) begin
        errors++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: hi=%h lo=%h expected hi=%h lo=%h",
                           k, op, a, b, hi_of(nar), lo_of(nar), nar ? m_hi_n : m_hi_w, nar ? m_lo_n : m_lo_w);
      end
      if (n > 0) begin
        checks++;
        if (!held) begin errors++; $display("FAIL rand_hold[%0d]: HI/LO changed while busy", k); end
      end
    end
  endtask

  // Reset during a divide aborts it; a MULT presented at release is accepted
  // at the first edge and the aborted divide never commits later.
  task automatic test_reset_mid;
    int n;
    issue(1'b0, 3'd2, 32'hFFFFFFF9, 32'd2);
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    m_hi_w = 32'd0; m_lo_w = 32'd0; m_hi_n = 32'd0; m_lo_n = 32'd0;
    checks++;
    if (w_busy !== 1'b0 || w_hi !== 32'd0 || w_lo !== 32'd0) begin
      errors++; $display("FAIL reset_mid_async: busy=%b hi=%h lo=%h expected 0/0/0", w_busy, w_hi, w_lo);
    end
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b1;
    w_start = 1'b1; w_op = 3'd0; w_a = 32'hFFFFFFFD; w_b = 32'd7;
    @(posedge clk); #1;
    w_start = 1'b0;
    checks++;
    if (w_busy !== 1'b1 || w_hi !== 32'd0 || w_lo !== 32'd0) begin
      errors++; $display("FAIL reset_first_start: busy=%b hi=%h lo=%h expected 1/0/0", w_busy, w_hi, w_lo);
    end
    n = 0;
    while (w_busy && n < 200) begin @(posedge clk); #1; n++; end
    ref_model(32, 3'd0, 32'hFFFFFFFD, 32'd7, m_hi_w, m_lo_w);
    checks++;
    if (n !== 5 || w_hi !== 32'hFFFFFFFF || w_lo !== 32'hFFFFFFEB) begin
      errors++; $display("FAIL reset_mult_after: cycles=%0d hi=%h lo=%h expected 5/ffffffff/ffffffeb", n, w_hi, w_lo);
    end
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (w_busy !== 1'b0 || w_hi !== m_hi_w || w_lo !== m_lo_w) begin
      errors++; $display("FAIL reset_no_late_commit: busy=%b hi=%h lo=%h expected 0/%h/%h", w_busy, w_hi, w_lo, m_hi_w, m_lo_w);
    end
  endtask

  initial begin
    test_reset();
    test_directed_wide();
    test_busy_ignore();
    test_back_to_back_narrow();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO width.
REQ-002 Parameter MUL_CYCLES, default 5: busy cycles for multiply; legal range 1..64.
REQ-003 Parameter DIV_CYCLES, default 10: busy cycles for divide; legal range 1..64.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset; asserted at 0.
REQ-006 start  in  1  request strobe, sampled on rising clk.
REQ-007 op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6..7 reserved (no-op).
REQ-008 a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
REQ-009 b  in  WIDTH  rt operand (divisor / multiplier).
REQ-010 busy  out  WIDTH-independent 1  high while a multiply/divide is in flight.
REQ-011 hi  out  WIDTH  HI register.
REQ-012 lo  out  WIDTH  LO register.

Function
REQ-013 States: IDLE, MUL, DIV; busy = (state != IDLE), registered.
REQ-014 In IDLE, start with op MULT/MULTU: latch a, b, op; enter MUL; load counter with MUL_CYCLES.
REQ-015 In IDLE, start with op DIV/DIVU: latch a, b, op; enter DIV; load counter with DIV_CYCLES.
REQ-016 Counter decrements once per cycle in MUL/DIV; at the edge where it reaches 0, HI/LO commit and state returns to IDLE.
REQ-017 Latency: start accepted at edge N -> busy high after edge N, HI/LO valid and busy low after edge N+CYCLES.
REQ-018 Back-to-back: a start in the cycle after busy falls is accepted with no gap cycle.
REQ-019 Any start while busy is ignored (no latch, no HI/LO change, counter unaffected); issuer must stall.
REQ-020 MTHI/MTLO in IDLE: hi (resp. lo) <= a at the next edge; busy stays low.
REQ-021 Reserved op codes with start: no state change.
REQ-022 MULT: {hi,lo} = signed a * signed b, full 2*WIDTH product; MULTU unsigned.
REQ-023 DIV: lo = quotient truncated toward zero, hi = remainder with dividend sign; DIVU unsigned.
REQ-024 Divide by zero (both DIV, DIVU): lo = all ones, hi = latched a.
REQ-025 Signed overflow (a = most-negative, b = -1, DIV): lo = most-negative, hi = 0.
REQ-026 HI/LO hold their values at all times other than REQ-016 and REQ-020 commits.
REQ-027 Results derive solely from operands latched at acceptance; changes on a, b, op while busy have no effect.

Reset
REQ-028 reset low asynchronously forces state IDLE, busy 0, hi 0, lo 0, counter 0, latched operands 0.
REQ-029 Reset asserted mid-operation aborts it; no partial result is ever committed.
REQ-030 First start honoured at the first rising edge after reset deasserts.

Structure
REQ-031 Op encodings (MDU_MULT..MDU_MTLO) and state encodings belong in the shared definitions package used by Control_Unit.
REQ-032 Counter width = clog2(max(MUL_CYCLES, DIV_CYCLES)+1), derived locally.
REQ-033 One sub-module, mdu_divider (combinational signed/unsigned quotient/remainder with REQ-024/025 handling), is natural; multiply stays inline.

Verification
REQ-034 MULT a=-3, b=7 -> after 5 cycles busy falls, hi=FFFFFFFF, lo=FFFFFFEB.
REQ-035 MULTU a=FFFFFFFF, b=2 -> hi=00000001, lo=FFFFFFFE; start issued while busy (MTLO 1234) ignored, lo unchanged until commit.
REQ-036 DIV a=-7, b=2 -> after 10 cycles lo=FFFFFFFD, hi=FFFFFFFF; DIVU a=7, b=0 -> lo=FFFFFFFF, hi=00000007.
REQ-037 DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0; MTHI a=DEADBEEF in IDLE -> hi=DEADBEEF next edge, busy never high.
REQ-038 reset low at cycle 3 of a DIV -> busy, hi, lo immediately 0; no commit after release; new MULT accepted on first edge.
REQ-039 Rerun REQ-034/036 with WIDTH=16, MUL_CYCLES=1, DIV_CYCLES=1 -> correct 16-bit results, busy high exactly one cycle, back-to-back start accepted.
